// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer.
// After reset it writes a fixed 7-entry init table to the audio codec through
// an external I2C master. It then arbitrates runtime register writes from two
// requesters round-robin. Every transaction is followed by an idle gap. NACKed
// transactions are re-issued up to MAX_RETRY times.
//
// Ports
//   clk, rstn            system clock, asynchronous active-low reset
//   req_valid[1:0]       per-requester write request (held until req_ack)
//   req_word0/1[15:0]    {reg[6:0], data[8:0]} for requester 0 / 1
//   req_ack[1:0]         one-cycle completion pulse to the granted requester
//   req_err              qualifies req_ack: 1 = failed after all retries
//   m_start              one-cycle launch pulse to the I2C master
//   m_word[23:0]         {I2C_ADDRESS, reg, data}, stable from m_start to m_done
//   m_busy, m_done,      I2C master status; m_nack qualifies m_done
//   m_nack
//   init_done            power-up table written successfully
//   init_err             sticky: power-up table failed (block is halted)
module codec_cfg_sequencer #(
  parameter logic [7:0] I2C_ADDRESS = 8'h34,
  parameter int         MAX_RETRY   = 3,
  parameter int         GAP_CYCLES  = 192
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_word0,
  input  logic [15:0] req_word1,
  output logic [1:0]  req_ack,
  output logic        req_err,
  output logic        m_start,
  output logic [23:0] m_word,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_nack,
  output logic        init_done,
  output logic        init_err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, GAP, ARB, RUN_ISSUE, RUN_WAIT, FAULT
  } state_t;

  state_t          state, state_d;
  logic [2:0]      init_idx, init_idx_d;
  logic [RW-1:0]   retry_cnt, retry_d;
  logic            retry_pend, pend_d;   // GAP exit re-issues the same word
  logic [GW-1:0]   gap_cnt, gap_d;
  logic            rr_ptr, ptr_d;
  logic            grant_id, gid_d;
  logic            gnt;
  logic [23:0]     word_d;
  logic            start_d, err_d, idone_d, ierr_d;
  logic [1:0]      ack_d;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = {7'h0F, 9'h000};
      3'd1:    init_word = {7'h06, 9'h070};
      3'd2:    init_word = {7'h04, 9'h014};
      3'd3:    init_word = {7'h01, 9'h117};
      3'd4:    init_word = {7'h05, 9'h000};
      3'd5:    init_word = {7'h09, 9'h001};
      default: init_word = {7'h06, 9'h060};
    endcase
  endfunction

  always_comb begin
    state_d    = state;
    init_idx_d = init_idx;
    retry_d    = retry_cnt;
    pend_d     = retry_pend;
    gap_d      = gap_cnt;
    ptr_d      = rr_ptr;
    gid_d      = grant_id;
    word_d     = m_word;
    start_d    = 1'b0;
    ack_d      = 2'b00;
    err_d      = 1'b0;
    idone_d    = init_done;
    ierr_d     = init_err;
    gnt        = 1'b0;

    case (state)
      INIT_ISSUE: begin
        if (!m_busy) begin
          start_d = 1'b1;
          word_d  = {I2C_ADDRESS, init_word(init_idx)};
          state_d = INIT_WAIT;
        end
      end

      INIT_WAIT: begin
        // m_nack wins over a simultaneous success indication
        if (m_done) begin
          gap_d = GW'(GAP_CYCLES - 1);
          if (!m_nack) begin
            retry_d = '0;
            pend_d  = 1'b0;
            state_d = GAP;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_d = retry_cnt + 1'b1;
            pend_d  = 1'b1;
            state_d = GAP;
          end else begin
            ierr_d  = 1'b1;
            state_d = FAULT;
          end
        end
      end

      GAP: begin
        if (gap_cnt == '0) begin
          if (retry_pend) begin
            pend_d  = 1'b0;
            state_d = init_done ? RUN_ISSUE : INIT_ISSUE;
          end else if (init_done) begin
            state_d = ARB;
          end else if (init_idx == 3'd6) begin
            idone_d = 1'b1;
            state_d = ARB;
          end else begin
            init_idx_d = init_idx + 3'd1;
            state_d    = INIT_ISSUE;
          end
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end

      ARB: begin
        if (req_valid != 2'b00) begin
          gnt     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
          gid_d   = gnt;
          ptr_d   = ~gnt;
          word_d  = {I2C_ADDRESS, gnt ? req_word1 : req_word0};
          retry_d = '0;
          pend_d  = 1'b0;
          state_d = RUN_ISSUE;
        end
      end

      RUN_ISSUE: begin
        if (!m_busy) begin
          start_d = 1'b1;
          state_d = RUN_WAIT;
        end
      end

      RUN_WAIT: begin
        if (m_done) begin
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = GAP;
          if (m_nack && (retry_cnt < RW'(MAX_RETRY))) begin
            retry_d = retry_cnt + 1'b1;
            pend_d  = 1'b1;
          end else begin
            // ack lands in the first GAP cycle
            ack_d   = grant_id ? 2'b10 : 2'b01;
            err_d   = m_nack;
            retry_d = '0;
            pend_d  = 1'b0;
          end
        end
      end

      default: state_d = FAULT;   // FAULT is terminal until reset
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= INIT_ISSUE;
      init_idx   <= 3'd0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      gap_cnt    <= '0;
      rr_ptr     <= 1'b0;
      grant_id   <= 1'b0;
      m_word     <= 24'h0;
      m_start    <= 1'b0;
      req_ack    <= 2'b00;
      req_err    <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      state      <= state_d;
      init_idx   <= init_idx_d;
      retry_cnt  <= retry_d;
      retry_pend <= pend_d;
      gap_cnt    <= gap_d;
      rr_ptr     <= ptr_d;
      grant_id   <= gid_d;
      m_word     <= word_d;
      m_start    <= start_d;
      req_ack    <= ack_d;
      req_err    <= err_d;
      init_done  <= idone_d;
      init_err   <= ierr_d;
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer: the stimulus pushes expected
// m_word values and req_ack/req_err results into queues. A negedge monitor
// pops and compares them whenever the DUT pulses m_start or req_ack.
module tb_codec_cfg_sequencer;
  localparam int GAP = 192;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_word0 = 16'h0;
  logic [15:0] req_word1 = 16'h0;
  logic [1:0]  req_ack;
  logic        req_err;
  logic        m_start;
  logic [23:0] m_word;
  logic        m_busy;
  logic        m_busy_m = 1'b0;
  logic        busy_hold = 1'b0;
  logic        m_done = 1'b0;
  logic        m_nack = 1'b0;
  logic        init_done;
  logic        init_err;

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int acks_seen = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit have_done = 1'b0;

  logic [23:0] exp_words[$];
  logic [2:0]  exp_acks[$];   // {req_err, req_ack}
  bit          nack_plan[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_busy = m_busy_m | busy_hold;

  codec_cfg_sequencer dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid),
    .req_word0(req_word0), .req_word1(req_word1),
    .req_ack(req_ack), .req_err(req_err),
    .m_start(m_start), .m_word(m_word),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .init_done(init_done), .init_err(init_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // I2C master model: busy for the transaction, done 4 cycles after start.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && m_start) begin
        m_busy_m = 1'b1;
        repeat (3) @(negedge clk);
        m_done = 1'b1;
        m_nack = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
        if (rstn) begin
          last_done_cyc = cyc;
          have_done = 1'b1;
        end
        @(negedge clk);
        m_done = 1'b0;
        m_nack = 1'b0;
        m_busy_m = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (m_start) begin
          starts_seen++;
          if (exp_words.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_start: got m_word=0x%0h required no start", m_word);
          end else begin
            chk("m_word", {8'h0, m_word}, {8'h0, exp_words.pop_front()});
          end
          if (have_done) chk("gap_before_start", {31'b0, (cyc - last_done_cyc) >= GAP}, 1);
        end
        if (req_ack != 2'b00) begin
          acks_seen++;
          if (exp_acks.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack: got {err,ack}=0x%0h required no ack", {req_err, req_ack});
          end else begin
            chk("ack_err", {29'b0, req_err, req_ack}, {29'b0, exp_acks.pop_front()});
          end
        end else if (req_err) begin
          checks++; failures++;
          $display("FAIL err_without_ack: got req_err=1 required 0");
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_m_start"}, {31'b0, m_start}, 0);
    chk({tag, "_m_word"}, {8'h0, m_word}, 0);
    chk({tag, "_ack_err"}, {29'b0, req_err, req_ack}, 0);
    chk({tag, "_init_flags"}, {30'b0, init_err, init_done}, 0);
  endtask

  task automatic push_init_words();
    exp_words.push_back(24'h341E00); exp_words.push_back(24'h340C70);
    exp_words.push_back(24'h340814); exp_words.push_back(24'h340317);
    exp_words.push_back(24'h340A00); exp_words.push_back(24'h341201);
    exp_words.push_back(24'h340C60);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    have_done = 1'b0;
    repeat (10) @(negedge clk);
    have_done = 1'b0;
    chk_outputs_zero("reset");
    rstn = 1'b1;
  endtask

  task automatic wait_init_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (init_done) break;
      @(negedge clk);
    end
    chk("init_done", {31'b0, init_done}, 1);
    chk("init_done_after_gap", {31'b0, (cyc - last_done_cyc) >= GAP}, 1);
    chk("init_err_clear", {31'b0, init_err}, 0);
  endtask

  task automatic wait_acks(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (acks_seen >= target) break;
      @(negedge clk);
    end
    chk("ack_count", acks_seen, target);
  endtask

  int base;

  initial begin
    // Power-up init, master always ACKs
    push_init_words();
    reset_pulse();
    wait_init_done(3000);
    chk("init_words_drained", exp_words.size(), 0);

    // Third init entry NACKed four times: issued four times, then FAULT
    exp_words.push_back(24'h341E00); exp_words.push_back(24'h340C70);
    for (int i = 0; i < 4; i++) exp_words.push_back(24'h340814);
    nack_plan.push_back(1'b0); nack_plan.push_back(1'b0);
    for (int i = 0; i < 4; i++) nack_plan.push_back(1'b1);
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      if (init_err) break;
      @(negedge clk);
    end
    chk("init_err_set", {31'b0, init_err}, 1);
    base = starts_seen;
    repeat (1000) @(negedge clk);
    chk("fault_no_start", starts_seen, base);
    chk("fault_init_done", {31'b0, init_done}, 0);
    chk("fault_init_err_sticky", {31'b0, init_err}, 1);
    chk("fault_words_drained", exp_words.size(), 0);

    // Both requesters held from power-up: served after init, alternating
    push_init_words();
    for (int i = 0; i < 2; i++) begin
      exp_words.push_back(24'h340217); exp_words.push_back(24'h340A00);
      exp_acks.push_back(3'b001);      exp_acks.push_back(3'b010);
    end
    req_word0 = 16'h0217; req_word1 = 16'h0A00; req_valid = 2'b11;
    base = acks_seen;
    reset_pulse();
    wait_init_done(3000);
    wait_acks(base + 4, 2000);
    req_valid = 2'b00;
    chk("rr_words_drained", exp_words.size(), 0);

    // Runtime request NACKed twice then ACKed
    repeat (GAP + 5) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_words.push_back(24'h340A55);
    nack_plan.push_back(1'b1); nack_plan.push_back(1'b1); nack_plan.push_back(1'b0);
    exp_acks.push_back(3'b001);
    base = acks_seen;
    req_word0 = 16'h0A55; req_valid = 2'b01;
    wait_acks(base + 1, 2000);
    req_valid = 2'b00;

    // Runtime request NACKed MAX_RETRY+1 times: error ack
    repeat (GAP + 5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_words.push_back(24'h341234);
      nack_plan.push_back(1'b1);
    end
    exp_acks.push_back(3'b110);
    base = acks_seen;
    req_word1 = 16'h1234; req_valid = 2'b10;
    wait_acks(base + 1, 2000);
    req_valid = 2'b00;
    chk("retry_words_drained", exp_words.size(), 0);

    // Busy master delays the start; reset in RUN_WAIT abandons the transfer
    repeat (GAP + 5) @(negedge clk);
    busy_hold = 1'b1;
    exp_words.push_back(24'h340C60);
    base = starts_seen;
    req_word0 = 16'h0C60; req_valid = 2'b01;
    repeat (50) @(negedge clk);
    chk("start_held_by_busy", starts_seen, base);
    busy_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (starts_seen > base) break;
      @(negedge clk);
    end
    chk("start_after_busy", starts_seen, base + 1);
    req_valid = 2'b00;
    @(negedge clk);
    #1 rstn = 1'b0;
    have_done = 1'b0;
    #1 chk_outputs_zero("async_reset");
    push_init_words();
    repeat (10) @(negedge clk);
    have_done = 1'b0;
    rstn = 1'b1;
    wait_init_done(3000);
    chk("restart_words_drained", exp_words.size(), 0);
    chk("no_pending_acks", exp_acks.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
